// File: rtl/mccpu_ctrl.sv
// Multicycle MIPS controller: sequences one shared memory port through fetch/decode/execute/memory/writeback.
// Optional build macro MCCTRL_SHIFT_EN adds sll/srl decoding.
module mccpu_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               Illegal,
    output logic               MemErr,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXE   = 4'd6,
        RWB    = 4'd7,
        IEXE   = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
`ifdef MCCTRL_SHIFT_EN
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
`endif

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             r_legal;
    logic [3:0]       r_aluop;
    logic             in_mem, expire;
    logic             pc_write, ir_write, mem_read, mem_write, reg_write, illegal, mem_err;
    logic [3:0]       alu_op;

    always_comb begin
        r_legal = 1'b1;
        r_aluop = ALU_NOP;
        case (Funct)
            FN_ADD, FN_ADDU: r_aluop = ALU_ADD;
            FN_SUB, FN_SUBU: r_aluop = ALU_SUB;
            FN_AND:          r_aluop = ALU_AND;
            FN_OR:           r_aluop = ALU_OR;
            FN_SLT:          r_aluop = ALU_SLT;
            FN_SLTU:         r_aluop = ALU_SLTU;
`ifdef MCCTRL_SHIFT_EN
            FN_SLL:          r_aluop = ALU_SLL;
            FN_SRL:          r_aluop = ALU_SRL;
`endif
            default:         r_legal = 1'b0;
        endcase
    end

    // Expiry fires in the cycle the wait count would reach MEM_TIMEOUT; a ready in that cycle wins.
    assign in_mem = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign expire = (MEM_TIMEOUT != 0) && in_mem && !MemReady && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        mem_err   = 1'b0;
        IorD      = 1'b0;
        EXTOp     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_NOP;
        NPCOp     = 2'b00;
        GPRSel    = 2'b00;
        WDSel     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'b01;
                alu_op   = ALU_ADD;
                if (expire) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end else if (MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                alu_op  = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW:            state_d = MEMADR;
                    OP_ADDI, OP_ORI, OP_ANDI: state_d = IEXE;
                    OP_BEQ:                  state_d = BRANCH;
                    OP_J, OP_JAL:            state_d = JUMP;
                    OP_RTYPE: begin
                        if (r_legal) begin
                            state_d = REXE;
                        end else begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                alu_op  = ALU_ADD;
                state_d = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                if (expire) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end else if (MemReady) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                reg_write = 1'b1;
                GPRSel    = 2'b01;
                WDSel     = 2'b01;
                state_d   = FETCH;
            end
            MEMWR: begin
                IorD = 1'b1;
                if (expire) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem_write = 1'b1;
                    if (MemReady) state_d = FETCH;
                end
            end
            REXE: begin
                ALUSrcA = 1'b1;
                alu_op  = r_aluop;
                state_d = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_ORI:  alu_op = ALU_OR;
                    OP_ANDI: alu_op = ALU_AND;
                    default: begin
                        EXTOp  = 1'b1;
                        alu_op = ALU_ADD;
                    end
                endcase
                state_d = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                GPRSel    = 2'b01;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_op   = ALU_SUB;
                NPCOp    = 2'b01;
                pc_write = Zero;
                state_d  = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                NPCOp    = 2'b10;
                if (Op == OP_JAL) begin
                    reg_write = 1'b1;
                    GPRSel    = 2'b10;
                    WDSel     = 2'b10;
                end
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        if (state_d != state_q || expire) begin
            cnt_d = '0;
        end else if (!MemReady) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset suppresses every side effect immediately, not just from the next edge.
    assign PCWrite   = pc_write & ~rst;
    assign IRWrite   = ir_write & ~rst;
    assign MemRead   = mem_read & ~rst;
    assign MemWrite  = mem_write & ~rst;
    assign RegWrite  = reg_write & ~rst;
    assign Illegal   = illegal & ~rst;
    assign MemErr    = mem_err & ~rst;
    assign ALUOp     = ALUOP_W'(alu_op);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed bench for mccpu_ctrl: per-cycle expected state and control word, built by hand and queued.
module tb_mccpu_ctrl;

    localparam int ALUOP_W     = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_IEXE   = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic               MemReady;
    logic               PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         NPCOp, GPRSel, WDSel;
    logic               Illegal, MemErr;
    logic [3:0]         dbg_state;

    mccpu_ctrl #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
        .Illegal(Illegal), .MemErr(MemErr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [21:0] ctl;
    logic [6:0]  enables;
    assign ctl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrcA,
                  ALUSrcB, ALUOp[3:0], NPCOp, GPRSel, WDSel, Illegal, MemErr};
    assign enables = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Illegal, MemErr};

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_q[$];
    logic [21:0] ctl_q[$];
    logic        rdy_q[$];

    logic [21:0] C_FETCH, C_FWAIT, C_FABORT, C_DEC, C_ILL, C_MADR, C_MRD, C_MWB;
    logic [21:0] C_MWR, C_MWABORT, C_RWB, C_IWB, C_JUMP, C_JAL;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic pcw, input logic irw, input logic iord,
                                       input logic mrd, input logic mwr, input logic rw,
                                       input logic ext, input logic asa, input logic [1:0] asb,
                                       input logic [3:0] aop, input logic [1:0] npc,
                                       input logic [1:0] gpr, input logic [1:0] wds,
                                       input logic ill, input logic merr);
        return {pcw, irw, iord, mrd, mwr, rw, ext, asa, asb, aop, npc, gpr, wds, ill, merr};
    endfunction

    function automatic logic [21:0] c_rexe(input logic [3:0] aop);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction

    function automatic logic [21:0] c_iexe(input logic ext, input logic [3:0] aop);
        return mk(0, 0, 0, 0, 0, 0, ext, 1, 2'b10, aop, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction

    function automatic logic [21:0] c_br(input logic z);
        return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd2, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [21:0] c);
        exp_q.push_back(st);
        rdy_q.push_back(rdy);
        ctl_q.push_back(c);
    endtask

    task automatic push_fd();
        push(S_FETCH, 1'b1, C_FETCH);
        push(S_DECODE, 1'b1, C_DEC);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op    = op;
        Funct = fn;
        Zero  = z;
    endtask

    // Called at posedge+1; each queued entry is one clock cycle.
    task automatic run_queue(input string name);
        int i;
        logic [3:0]  es;
        logic [21:0] ec;
        i = 0;
        while (exp_q.size() > 0) begin
            MemReady = rdy_q.pop_front();
            es = exp_q.pop_front();
            ec = ctl_q.pop_front();
            #1;
            check($sformatf("%s.c%0d.state", name, i), 32'(dbg_state), 32'(es));
            check($sformatf("%s.c%0d.ctl", name, i), 32'(ctl), 32'(ec));
            i++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        C_FETCH   = mk(1, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'd1, 2'b00, 2'b00, 2'b00, 0, 0);
        C_FWAIT   = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 4'd1, 2'b00, 2'b00, 2'b00, 0, 0);
        C_FABORT  = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 4'd1, 2'b00, 2'b00, 2'b00, 0, 1);
        C_DEC     = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 4'd1, 2'b00, 2'b00, 2'b00, 0, 0);
        C_ILL     = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 4'd1, 2'b00, 2'b00, 2'b00, 1, 0);
        C_MADR    = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 4'd1, 2'b00, 2'b00, 2'b00, 0, 0);
        C_MRD     = mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00, 0, 0);
        C_MWB     = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00, 2'b01, 2'b01, 0, 0);
        C_MWR     = mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00, 0, 0);
        C_MWABORT = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00, 0, 1);
        C_RWB     = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00, 0, 0);
        C_IWB     = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00, 2'b01, 2'b00, 0, 0);
        C_JUMP    = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b10, 2'b00, 2'b00, 0, 0);
        C_JAL     = mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0, 2'b10, 2'b10, 2'b10, 0, 0);

        // Clock/reset: hold reset with MemReady high, enables must stay low.
        rst = 1'b1;
        MemReady = 1'b1;
        set_instr(OP_LW, 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(dbg_state), 32'(S_FETCH));
        check("rst.enables", 32'(enables), 32'd0);
        rst = 1'b0;

        set_instr(OP_LW, 6'd0, 1'b0);
        push_fd(); push(S_MEMADR, 1, C_MADR); push(S_MEMRD, 1, C_MRD); push(S_MEMWB, 1, C_MWB);
        run_queue("lw");

        set_instr(OP_SW, 6'd0, 1'b0);
        push_fd(); push(S_MEMADR, 1, C_MADR); push(S_MEMWR, 1, C_MWR);
        run_queue("sw");

        set_instr(OP_R, 6'b100000, 1'b0);
        push_fd(); push(S_REXE, 1, c_rexe(4'd1)); push(S_RWB, 1, C_RWB);
        run_queue("add");

        set_instr(OP_R, 6'b100011, 1'b0);
        push_fd(); push(S_REXE, 1, c_rexe(4'd2)); push(S_RWB, 1, C_RWB);
        run_queue("subu");

        set_instr(OP_R, 6'b101011, 1'b0);
        push_fd(); push(S_REXE, 1, c_rexe(4'd6)); push(S_RWB, 1, C_RWB);
        run_queue("sltu");

        set_instr(OP_R, 6'b100100, 1'b0);
        push_fd(); push(S_REXE, 1, c_rexe(4'd3)); push(S_RWB, 1, C_RWB);
        run_queue("and");

        set_instr(OP_ADDI, 6'b111111, 1'b0);
        push_fd(); push(S_IEXE, 1, c_iexe(1, 4'd1)); push(S_IWB, 1, C_IWB);
        run_queue("addi");

        set_instr(OP_ORI, 6'd0, 1'b0);
        push_fd(); push(S_IEXE, 1, c_iexe(0, 4'd4)); push(S_IWB, 1, C_IWB);
        run_queue("ori");

        set_instr(OP_ANDI, 6'd0, 1'b0);
        push_fd(); push(S_IEXE, 1, c_iexe(0, 4'd3)); push(S_IWB, 1, C_IWB);
        run_queue("andi");

        set_instr(OP_BEQ, 6'd0, 1'b1);
        push_fd(); push(S_BRANCH, 1, c_br(1'b1));
        run_queue("beq_taken");

        set_instr(OP_BEQ, 6'd0, 1'b0);
        push_fd(); push(S_BRANCH, 1, c_br(1'b0));
        run_queue("beq_not");

        set_instr(OP_J, 6'd0, 1'b0);
        push_fd(); push(S_JUMP, 1, C_JUMP);
        run_queue("j");

        set_instr(OP_JAL, 6'd0, 1'b0);
        push_fd(); push(S_JUMP, 1, C_JAL);
        run_queue("jal");

        set_instr(6'b111111, 6'd0, 1'b0);
        push(S_FETCH, 1, C_FETCH); push(S_DECODE, 1, C_ILL);
        run_queue("ill_op");

        set_instr(OP_R, 6'b111111, 1'b0);
        push(S_FETCH, 1, C_FETCH); push(S_DECODE, 1, C_ILL);
        run_queue("ill_funct");

        set_instr(OP_R, 6'b000000, 1'b0);
`ifdef MCCTRL_SHIFT_EN
        push_fd(); push(S_REXE, 1, c_rexe(4'd8)); push(S_RWB, 1, C_RWB);
        run_queue("sll");
        set_instr(OP_R, 6'b000010, 1'b0);
        push_fd(); push(S_REXE, 1, c_rexe(4'd9)); push(S_RWB, 1, C_RWB);
        run_queue("srl");
`else
        push(S_FETCH, 1, C_FETCH); push(S_DECODE, 1, C_ILL);
        run_queue("sll_ill");
`endif

        // Fetch stall, then sw whose write never completes: abort on the 4th MEMWR cycle.
        set_instr(OP_SW, 6'd0, 1'b0);
        push(S_FETCH, 0, C_FWAIT); push(S_FETCH, 0, C_FWAIT);
        push_fd(); push(S_MEMADR, 1, C_MADR);
        for (int k = 0; k < 3; k++) push(S_MEMWR, 0, C_MWR);
        push(S_MEMWR, 0, C_MWABORT);
        run_queue("sw_timeout");

        // Same, but ready arrives in the would-be expiry cycle.
        push_fd(); push(S_MEMADR, 1, C_MADR);
        for (int k = 0; k < 3; k++) push(S_MEMWR, 0, C_MWR);
        push(S_MEMWR, 1, C_MWR);
        run_queue("sw_late_ready");

        // Fetch that never completes aborts and retries.
        set_instr(OP_J, 6'd0, 1'b0);
        for (int k = 0; k < 3; k++) push(S_FETCH, 0, C_FWAIT);
        push(S_FETCH, 0, C_FABORT);
        push_fd(); push(S_JUMP, 1, C_JUMP);
        run_queue("fetch_timeout");

        // Reset while waiting in MEMRD.
        set_instr(OP_LW, 6'd0, 1'b0);
        push_fd(); push(S_MEMADR, 1, C_MADR); push(S_MEMRD, 0, C_MRD);
        run_queue("lw_pre_rst");
        rst = 1'b1;
        #1;
        check("mid_rst.state", 32'(dbg_state), 32'(S_FETCH));
        check("mid_rst.enables", 32'(enables), 32'd0);
        MemReady = 1'b1;
        #1;
        check("mid_rst.enables_rdy", 32'(enables), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst.hold_state", 32'(dbg_state), 32'(S_FETCH));
        rst = 1'b0;
        push_fd(); push(S_MEMADR, 1, C_MADR); push(S_MEMRD, 1, C_MRD); push(S_MEMWB, 1, C_MWB);
        run_queue("lw_after_rst");

        push(S_FETCH, 0, C_FWAIT);
        run_queue("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
